ocr_rx_stream_packer: RTL and testbench

- Buffers complete OCR result vectors from the recognition core and serialises each one as a NULL-terminated character string.
- Output is a sequence of PIO-width words for HPS readout over the AHIM bridge.
- Successor to the combinational unpack/pack helpers: adds variable string length, a multi-entry result queue, a valid/ready output handshake and drop accounting.

---
 rtl/ocr_rx_stream_packer_if.sv | 32 +++
 rtl/ocr_rx_stream_packer.sv | 246 ++++++++++++++++++++++++
 tb/tb_ocr_rx_stream_packer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ocr_rx_stream_packer_if.sv
// Bundle of the OCR result input, the PIO word output handshake and the queue status lines.
// The packer uses the slave modport; whoever drives results and reads words uses master.
interface ocr_rx_stream_packer_if #(
    parameter int CHAR_WIDTH     = 8,
    parameter int MAX_OUT_L      = 16,
    parameter int PIO_DATA_WIDTH = 64,
    parameter int FIFO_DEPTH     = 4
);
    localparam int LEN_W = $clog2(MAX_OUT_L + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic                            ocr_valid;
    logic [MAX_OUT_L*CHAR_WIDTH-1:0] ocr_data;
    logic [LEN_W-1:0]                ocr_len;
    logic                            ocr_ready;
    logic                            pio_valid;
    logic                            pio_ready;
    logic [PIO_DATA_WIDTH-1:0]       pio_data;
    logic                            pio_last;
    logic [CNT_W-1:0]                fifo_count;
    logic [15:0]                     drop_cnt;

    modport master (
        output ocr_valid, ocr_data, ocr_len, pio_ready,
        input  ocr_ready, pio_valid, pio_data, pio_last, fifo_count, drop_cnt
    );

    modport slave (
        input  ocr_valid, ocr_data, ocr_len, pio_ready,
        output ocr_ready, pio_valid, pio_data, pio_last, fifo_count, drop_cnt
    );
endinterface

// File: rtl/ocr_rx_stream_packer.sv
// Queues OCR result vectors and emits each as a NULL-terminated string packed first-char-in-MSB
// into PIO words. Define OCR_RX_CKSUM_EN to append an XOR/length checksum word to every string.
module ocr_rx_stream_packer #(
    parameter int                    CHAR_WIDTH     = 8,
    parameter int                    MAX_OUT_L      = 16,
    parameter int                    PIO_DATA_WIDTH = 64,
    parameter int                    FIFO_DEPTH     = 4,
    parameter logic [CHAR_WIDTH-1:0] NULL_CHAR      = 8'h00
) (
    input logic                   clk,
    input logic                   reset_n,
    ocr_rx_stream_packer_if.slave io
);
    localparam int CPW    = PIO_DATA_WIDTH / CHAR_WIDTH;
    localparam int LEN_W  = $clog2(MAX_OUT_L + 1);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int DATA_W = MAX_OUT_L * CHAR_WIDTH;

`ifdef OCR_RX_CKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT, S_CKSUM} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT} state_t;
`endif

    // Word k of the string: character k*CPW+j lands in slot j counted down from the MSBs.
    function automatic logic [PIO_DATA_WIDTH-1:0] pack_word(
        input logic [DATA_W-1:0] d,
        input logic [LEN_W-1:0]  len,
        input logic [LEN_W-1:0]  k
    );
        logic [PIO_DATA_WIDTH-1:0] w;
        int                        pos;
        w = '0;
        for (int j = 0; j < CPW; j++) begin
            pos = int'(k) * CPW + j;
            w[PIO_DATA_WIDTH-(j+1)*CHAR_WIDTH +: CHAR_WIDTH] = NULL_CHAR;
            for (int i = 0; i < MAX_OUT_L; i++) begin
                if ((i == pos) && (i < int'(len))) begin
                    w[PIO_DATA_WIDTH-(j+1)*CHAR_WIDTH +: CHAR_WIDTH] = d[i*CHAR_WIDTH +: CHAR_WIDTH];
                end else begin
                    w = w;
                end
            end
        end
        return w;
    endfunction

    function automatic logic [LEN_W-1:0] word_count(input logic [LEN_W-1:0] len);
        return LEN_W'((int'(len) + CPW) / CPW);
    endfunction

`ifdef OCR_RX_CKSUM_EN
    function automatic logic [PIO_DATA_WIDTH-1:0] cksum_word(
        input logic [DATA_W-1:0] d,
        input logic [LEN_W-1:0]  len
    );
        logic [PIO_DATA_WIDTH-1:0] w;
        logic [CHAR_WIDTH-1:0]     x;
        x = '0;
        for (int i = 0; i < MAX_OUT_L; i++) begin
            if (i < int'(len)) begin
                x = x ^ d[i*CHAR_WIDTH +: CHAR_WIDTH];
            end else begin
                x = x;
            end
        end
        w = '0;
        w[CHAR_WIDTH-1:0]            = x;
        w[2*CHAR_WIDTH-1:CHAR_WIDTH] = CHAR_WIDTH'(len);
        return w;
    endfunction
`endif

    logic [DATA_W-1:0]         q_data_r [FIFO_DEPTH];
    logic [LEN_W-1:0]          q_len_r  [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]          count_r, count_next_s;
    logic                      ocr_ready_r;
    logic [15:0]               drop_cnt_r;
    state_t                    state_r, state_next_s;
    logic [DATA_W-1:0]         work_data_r;
    logic [LEN_W-1:0]          work_len_r;
    logic [LEN_W-1:0]          idx_r, wcnt_r, idx_next_s;
    logic [PIO_DATA_WIDTH-1:0] pio_data_r;
    logic                      pio_last_r, pio_valid_r;
    logic                      full_s, push_s, drop_s, pop_s, last_word_s;
    logic [LEN_W-1:0]          in_len_s, head_len_s;
    logic [DATA_W-1:0]         head_data_s;

    // Fullness is judged on the pre-pop count, so a push arriving with a pop while full is still dropped.
    always_comb begin
        full_s       = (count_r == CNT_W'(FIFO_DEPTH));
        push_s       = io.ocr_valid && !full_s;
        drop_s       = io.ocr_valid && full_s;
        pop_s        = (state_r == S_LOAD);
        in_len_s     = (io.ocr_len > LEN_W'(MAX_OUT_L)) ? LEN_W'(MAX_OUT_L) : io.ocr_len;
        head_data_s  = q_data_r[rd_ptr_r];
        head_len_s   = q_len_r[rd_ptr_r];
        idx_next_s   = idx_r + LEN_W'(1);
        last_word_s  = (idx_r == (wcnt_r - LEN_W'(1)));
        count_next_s = count_r;
        if (push_s && !pop_s) begin
            count_next_s = count_r + CNT_W'(1);
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - CNT_W'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Result queue storage, pointers, occupancy, ready flag and saturating drop counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_data_r[i] <= '0;
                q_len_r[i]  <= '0;
            end
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            ocr_ready_r <= 1'b1;
            drop_cnt_r  <= 16'd0;
        end else begin
            if (push_s) begin
                q_data_r[wr_ptr_r] <= io.ocr_data;
                q_len_r[wr_ptr_r]  <= in_len_s;
                wr_ptr_r           <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'd1;
            end
            count_r     <= count_next_s;
            ocr_ready_r <= (count_next_s != CNT_W'(FIFO_DEPTH));
        end
    end

    // Output sequencer next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (count_r != CNT_W'(0)) state_next_s = S_LOAD;
                else                      state_next_s = S_IDLE;
            end
            S_LOAD: state_next_s = S_EMIT;
            S_EMIT: begin
                if (io.pio_ready && last_word_s) begin
`ifdef OCR_RX_CKSUM_EN
                    state_next_s = S_CKSUM;
`else
                    state_next_s = (count_r != CNT_W'(0)) ? S_LOAD : S_IDLE;
`endif
                end else begin
                    state_next_s = S_EMIT;
                end
            end
`ifdef OCR_RX_CKSUM_EN
            S_CKSUM: begin
                if (io.pio_ready) state_next_s = (count_r != CNT_W'(0)) ? S_LOAD : S_IDLE;
                else              state_next_s = S_CKSUM;
            end
`endif
            default: state_next_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_r <= S_IDLE;
        else          state_r <= state_next_s;
    end

    // Working string and registered PIO word; the next word is prepared on each handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            work_data_r <= '0;
            work_len_r  <= '0;
            idx_r       <= '0;
            wcnt_r      <= '0;
            pio_data_r  <= '0;
            pio_last_r  <= 1'b0;
            pio_valid_r <= 1'b0;
        end else begin
            pio_valid_r <= (state_next_s == S_EMIT)
`ifdef OCR_RX_CKSUM_EN
                           || (state_next_s == S_CKSUM)
`endif
                           ;
            case (state_r)
                S_LOAD: begin
                    work_data_r <= head_data_s;
                    work_len_r  <= head_len_s;
                    idx_r       <= '0;
                    wcnt_r      <= word_count(head_len_s);
                    pio_data_r  <= pack_word(head_data_s, head_len_s, LEN_W'(0));
`ifdef OCR_RX_CKSUM_EN
                    pio_last_r  <= 1'b0;
`else
                    pio_last_r  <= (word_count(head_len_s) == LEN_W'(1));
`endif
                end
                S_EMIT: begin
                    if (io.pio_ready && !last_word_s) begin
                        idx_r      <= idx_next_s;
                        pio_data_r <= pack_word(work_data_r, work_len_r, idx_next_s);
`ifdef OCR_RX_CKSUM_EN
                        pio_last_r <= 1'b0;
`else
                        pio_last_r <= (idx_next_s == (wcnt_r - LEN_W'(1)));
`endif
                    end else if (io.pio_ready) begin
`ifdef OCR_RX_CKSUM_EN
                        pio_data_r <= cksum_word(work_data_r, work_len_r);
                        pio_last_r <= 1'b1;
`else
                        pio_data_r <= '0;
                        pio_last_r <= 1'b0;
`endif
                    end
                end
`ifdef OCR_RX_CKSUM_EN
                S_CKSUM: begin
                    if (io.pio_ready) begin
                        pio_data_r <= '0;
                        pio_last_r <= 1'b0;
                    end
                end
`endif
                default: begin
                    pio_last_r <= pio_last_r;
                end
            endcase
        end
    end

    assign io.ocr_ready  = ocr_ready_r;
    assign io.pio_valid  = pio_valid_r;
    assign io.pio_data   = pio_data_r;
    assign io.pio_last   = pio_last_r;
    assign io.fifo_count = count_r;
    assign io.drop_cnt   = drop_cnt_r;
endmodule

// File: tb/tb_ocr_rx_stream_packer.sv
// Directed bench for ocr_rx_stream_packer: a string/word model predicts every accepted word,
// a negedge monitor checks order, data, last flag and hold-under-stall, plus literal spot checks.
module tb_ocr_rx_stream_packer;
`ifdef OCR_RX_CKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic clk;
    logic reset_n;
    int   tests;
    int   fails;

    logic [63:0] exp_data_q[$];
    bit          exp_last_q[$];
    logic [63:0] got_data[$];
    bit          got_last[$];

    ocr_rx_stream_packer_if bus ();

    ocr_rx_stream_packer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] str2data(input string s);
        logic [127:0] d;
        d = '0;
        for (int i = 0; i < s.len() && i < 16; i++) d[i*8 +: 8] = s[i];
        return d;
    endfunction

    // Spec-level model: build the NULL-terminated string and cut it into 8-char words.
    function automatic void model_push(input logic [127:0] d, input int len_in);
        int          len;
        int          nwords;
        int          p;
        logic [63:0] w;
        logic [7:0]  ch;
        logic [7:0]  x;
        len    = (len_in > 16) ? 16 : len_in;
        nwords = (len + 1 + 7) / 8;
        x      = 8'h00;
        for (int k = 0; k < nwords; k++) begin
            w = 64'h0;
            for (int j = 0; j < 8; j++) begin
                p  = k * 8 + j;
                ch = (p < len) ? d[p*8 +: 8] : 8'h00;
                w  = {w[55:0], ch};
            end
            exp_data_q.push_back(w);
            exp_last_q.push_back((k == nwords - 1) && (CK == 0));
        end
        for (int i = 0; i < len; i++) x = x ^ d[i*8 +: 8];
        if (CK != 0) begin
            exp_data_q.push_back({48'h0, 8'(len), x});
            exp_last_q.push_back(1'b1);
        end
    endfunction

    // Monitor: every handshake is checked against the model; stalled words must hold.
    initial begin
        bit          stall_v;
        logic [63:0] prev_data;
        logic        prev_last;
        stall_v   = 1'b0;
        prev_data = 64'h0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stall_v = 1'b0;
            end else begin
                if (stall_v) begin
                    check("hold_valid", bus.pio_valid, 1'b1);
                    check("hold_data", bus.pio_data, prev_data);
                    check("hold_last", bus.pio_last, prev_last);
                end
                if (bus.pio_valid && bus.pio_ready) begin
                    got_data.push_back(bus.pio_data);
                    got_last.push_back(bus.pio_last);
                    if (exp_data_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_word: got %h expected none", bus.pio_data);
                    end else begin
                        check("model_data", bus.pio_data, exp_data_q.pop_front());
                        check("model_last", bus.pio_last, exp_last_q.pop_front());
                    end
                end
                stall_v   = bus.pio_valid && !bus.pio_ready;
                prev_data = bus.pio_data;
                prev_last = bus.pio_last;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string s, input int len, input bit accept);
        logic [127:0] d;
        d = str2data(s);
        bus.ocr_valid = 1'b1;
        bus.ocr_data  = d;
        bus.ocr_len   = 5'(len);
        @(posedge clk);
        #1;
        bus.ocr_valid = 1'b0;
        if (accept) model_push(d, len);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            if (exp_data_q.size() == 0 && !bus.pio_valid && bus.fifo_count == 3'd0) done = 1'b1;
            else cycles(1);
        end
        check("drain_done", done, 1'b1);
        cycles(1);
    endtask

    task automatic check_got(input int idx, input logic [63:0] d, input bit l);
        if (idx >= got_data.size()) begin
            tests++;
            fails++;
            $display("FAIL got_index: got %0d words expected more than %0d", got_data.size(), idx);
        end else begin
            check("lit_data", got_data[idx], d);
            check("lit_last", got_last[idx], l);
        end
    endtask

    initial begin
        int base;
        tests         = 0;
        fails         = 0;
        reset_n       = 1'b1;
        bus.ocr_valid = 1'b0;
        bus.ocr_data  = '0;
        bus.ocr_len   = 5'd0;
        bus.pio_ready = 1'b1;
        #2 reset_n = 1'b0;
        cycles(2);
        check("rst_pio_valid", bus.pio_valid, 1'b0);
        check("rst_pio_data", bus.pio_data, 64'h0);
        check("rst_pio_last", bus.pio_last, 1'b0);
        check("rst_fifo_count", bus.fifo_count, 3'd0);
        check("rst_drop_cnt", bus.drop_cnt, 16'd0);
        check("rst_ocr_ready", bus.ocr_ready, 1'b1);
        reset_n = 1'b1;
        cycles(1);

        // Single-word string and latency.
        base = got_data.size();
        push("ABC1234", 7, 1'b1);
        check("lat_e0_valid", bus.pio_valid, 1'b0);
        cycles(1);
        check("lat_e1_valid", bus.pio_valid, 1'b0);
        cycles(1);
        check("lat_e2_valid", bus.pio_valid, 1'b1);
        check("abc_live_data", bus.pio_data, 64'h4142_4331_3233_3400);
        drain();
        check_got(base, 64'h4142_4331_3233_3400, CK == 0);

        // Exactly 8 chars: terminator spills into a second word.
        base = got_data.size();
        push("12345678", 8, 1'b1);
        drain();
        check_got(base, 64'h3132_3334_3536_3738, 1'b0);
        check_got(base + 1, 64'h0, CK == 0);

        // Empty string and an over-long length clamped to 16.
        base = got_data.size();
        push("", 0, 1'b1);
        push("ABCDEFGHIJKLMNOP", 20, 1'b1);
        drain();
        check_got(base, 64'h0, CK == 0);
        check_got(base + 1 + CK, 64'h4142_4344_4546_4748, 1'b0);
        check_got(base + 2 + CK, 64'h494A_4B4C_4D4E_4F50, 1'b0);
        check_got(base + 3 + CK, 64'h0, CK == 0);

        // Stall, fill the queue, drop one, then release.
        base = got_data.size();
        bus.pio_ready = 1'b0;
        push("S1", 2, 1'b1);
        cycles(2);
        check("stall_emit_valid", bus.pio_valid, 1'b1);
        check("stall_cnt0", bus.fifo_count, 3'd0);
        push("S2", 2, 1'b1);
        push("S3", 2, 1'b1);
        push("S4", 2, 1'b1);
        check("stall_cnt3", bus.fifo_count, 3'd3);
        check("stall_ready3", bus.ocr_ready, 1'b1);
        push("S5", 2, 1'b1);
        check("full_cnt4", bus.fifo_count, 3'd4);
        check("full_ready0", bus.ocr_ready, 1'b0);
        push("XX", 2, 1'b0);
        check("drop_cnt1", bus.drop_cnt, 16'd1);
        check("drop_cnt_fifo", bus.fifo_count, 3'd4);
        cycles(10);
        check("stall_still_s1", bus.pio_data, 64'h5331_0000_0000_0000);
        bus.pio_ready = 1'b1;
        drain();
        check("after_ready", bus.ocr_ready, 1'b1);
        check("stall_words", 64'(got_data.size() - base), 64'(5 * (CK + 1)));
        check_got(base, 64'h5331_0000_0000_0000, CK == 0);
        check_got(base + 1 + CK, 64'h5332_0000_0000_0000, CK == 0);
        check_got(base + 4 * (1 + CK), 64'h5335_0000_0000_0000, CK == 0);

        // pio_ready toggling every cycle during a two-word string.
        base = got_data.size();
        bus.pio_ready = 1'b0;
        push("12345678", 8, 1'b1);
        for (int i = 0; i < 16; i++) begin
            bus.pio_ready = ~bus.pio_ready;
            cycles(1);
        end
        bus.pio_ready = 1'b1;
        drain();
        check("toggle_words", 64'(got_data.size() - base), 64'(2 + CK));
        check_got(base, 64'h3132_3334_3536_3738, 1'b0);
        check_got(base + 1, 64'h0, CK == 0);

        // Reset in the middle of EMIT with a queued result and a nonzero drop count.
        bus.pio_ready = 1'b0;
        push("HELLO", 5, 1'b1);
        cycles(3);
        push("BYE", 3, 1'b1);
        check("pre_rst_valid", bus.pio_valid, 1'b1);
        check("pre_rst_cnt", bus.fifo_count, 3'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.pio_valid, 1'b0);
        check("mid_rst_cnt", bus.fifo_count, 3'd0);
        check("mid_rst_drop", bus.drop_cnt, 16'd0);
        check("mid_rst_ready", bus.ocr_ready, 1'b1);
        exp_data_q.delete();
        exp_last_q.delete();
        cycles(1);
        reset_n       = 1'b1;
        bus.pio_ready = 1'b1;
        cycles(1);
        base = got_data.size();
        push("OK", 2, 1'b1);
        drain();
        check_got(base, 64'h4F4B_0000_0000_0000, CK == 0);

        // Two-character string; with the checksum build the XOR/length word follows.
        base = got_data.size();
        push("AB", 2, 1'b1);
        drain();
        check_got(base, 64'h4142_0000_0000_0000, CK == 0);
        if (CK != 0) check_got(base + 1, 64'h0000_0000_0000_0203, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
